geofence_sort_ctrl: RTL and testbench
=====================================

# geofence_sort_ctrl

Angular-sort scheduler for the geofence engine. It captures the six receiver samples (X, Y, R) of one object and time-shares a single signed cross-product unit across a fixed 16-step bubble-sort schedule. It then streams the six samples back in counter-clockwise order around receiver 0. It sits between the sample input port and the area/inside-test datapath, which requires the hexagon vertices in angular order.

## Interface
- No parameters; point count fixed at 6, schedule fixed at 4 passes × 4 compares.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample present on X/Y/R this cycle
- X  in  10  receiver x coordinate, unsigned
- Y  in  10  receiver y coordinate, unsigned
- R  in  11  receiver distance, unsigned, carried through untouched
- busy  out  1  high while sorting or emitting; in_valid ignored while high
- out_valid  out  1  sorted sample on out_* this cycle
- out_last  out  1  high with the 6th out_valid
- out_idx  out  3  original capture index (0..5) of emitted sample
- out_X / out_Y  out  10  emitted coordinates
- out_R  out  11  emitted distance

## Operation
- States: LOAD, SORT, EMIT.
- LOAD: busy=0. Each cycle with in_valid=1 writes {X,Y,R,idx=cnt} into slot cnt, then cnt++. After slot 5 is written, go to SORT.
- Slot 0 is the anchor P0. It never moves.
- SORT: 16 cycles, one compare per cycle. Pass p=0..3 compares slot pairs (j, j+1) for j=1..4 in order.
- Compare arithmetic for a in slot j and b in slot j+1:
  - ax = Xa−X0 and ay = Ya−Y0, signed 11-bit; bx and by likewise for b.
  - cross = ax·by − bx·ay, full 23-bit signed, no truncation.
- cross<0 → swap slots j and j+1, registered at the end of the cycle. The next compare sees the swapped contents.
- cross≥0 → no swap. Collinear points keep capture order, so the sort is stable.
- Exactly one multiplier pair is instantiated and shared by all 16 compares.
- EMIT: 6 cycles. Cycle e presents slot e (e=0..5) on out_*, with out_valid=1 and out_last=(e==5). Then return to LOAD with cnt=0.
- Inputs assumed to have P1..P5 in the closed half-plane around P0, which gives a total order. Otherwise the output order is whatever the fixed schedule produces; no error flag.
- in_valid during SORT or EMIT is dropped and does not affect cnt.

## Timing
- Reset: state=LOAD, cnt=0, busy=0, out_valid=0, out_last=0, out_idx=0, out_X=out_Y=out_R=0. Slot contents are don't-care.
- Reset asserted mid-SORT or mid-EMIT aborts immediately. out_valid=0 on the next cycle. Partial results are never emitted.
- 6th sample presented in cycle c:
  - busy=1 in cycles c+1..c+22.
  - SORT occupies c+1..c+16.
  - out_valid=1 in c+17..c+22; out_last in c+22.
  - busy=0 in c+23, which can accept a new sample.
- Fixed latency 17 cycles from 6th sample to first output. It is independent of data and swap count.
- out_* are registered. out_X/out_Y/out_R/out_idx hold their last value when out_valid=0.
- Gaps in in_valid during LOAD are allowed; there is no timeout.

## Test plan
- Scrambled hexagon → sorted order:
  - Input P0(100,100), P1(100,350), P2(450,300), P3(400,100), P4(300,400), P5(50,300), R=10·idx.
  - Required: out_idx sequence 0,3,2,4,1,5 with matching X/Y/R; first out_valid 17 cycles after P5; out_last on idx 5.
- Pre-sorted input → identity:
  - Input P0(100,100), (400,100), (450,300), (300,400), (100,350), (50,300).
  - Required: out_idx 0,1,2,3,4,5, and no swap occurs in any of the 16 cycles.
- Collinear tie:
  - P1=(200,200) and P2=(300,300) both on the 45° ray from P0(100,100); the rest as in test 2.
  - Required: idx 1 emitted before idx 2 (stable). cross for that pair computes 0.
- Extremes and busy handling:
  - P0=(1023,0), P1=(0,0), P2=(0,1023), etc.
  - Required: cross correct at the full 23-bit range, with no wrap.
  - in_valid pulsed throughout SORT/EMIT → ignored; the next object captures from idx 0.
- Reset during SORT cycle 8:
  - Required: out_valid never asserts. busy=0 the cycle after reset deasserts. A fresh 6-sample object then sorts correctly.
- Back-to-back objects with in_valid continuously high:
  - Required: samples offered during busy are dropped. Two complete 6-cycle output bursts, each with correct order. busy low for exactly the capture windows.

Source files
------------

// File: rtl/geofence_sort_ctrl_if.sv
// Sample-in / sorted-sample-out bundle for the geofence angular-sort scheduler.
interface geofence_sort_ctrl_if;
    logic        in_valid;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic [10:0] R;
    logic        busy;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_idx;
    logic [9:0]  out_X;
    logic [9:0]  out_Y;
    logic [10:0] out_R;

    modport master (
        output in_valid, X, Y, R,
        input  busy, out_valid, out_last, out_idx, out_X, out_Y, out_R
    );

    modport slave (
        input  in_valid, X, Y, R,
        output busy, out_valid, out_last, out_idx, out_X, out_Y, out_R
    );
endinterface

// File: rtl/geofence_sort_ctrl.sv
// Captures six receiver samples, bubble-sorts slots 1..5 counter-clockwise around
// slot 0 with one shared cross-product unit, then streams the slots out in order.
module geofence_sort_ctrl (
    input logic                 clk,
    input logic                 reset,
    geofence_sort_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        EMIT = 2'd2
    } state_t;

    // slot word layout: {idx[33:31], X[30:21], Y[20:11], R[10:0]}
    state_t       state_r;
    state_t       state_nx_s;
    logic [33:0]  slot_r [0:5];
    logic [2:0]   cnt_r;
    logic [3:0]   step_r;
    logic         busy_r;
    logic         out_valid_r;
    logic         out_last_r;
    logic [2:0]   out_idx_r;
    logic [9:0]   out_x_r;
    logic [9:0]   out_y_r;
    logic [10:0]  out_r_r;

    logic [2:0]          ja_s;
    logic [2:0]          jb_s;
    logic [2:0]          emit_nx_s;
    logic signed [10:0]  ax_s;
    logic signed [10:0]  ay_s;
    logic signed [10:0]  bx_s;
    logic signed [10:0]  by_s;
    logic signed [21:0]  prod_ab_s;
    logic signed [21:0]  prod_ba_s;
    logic signed [22:0]  cross_s;
    logic                swap_s;

    // Pass step s compares slots (s%4)+1 and (s%4)+2; the pair is chosen by muxing, the multipliers are shared.
    assign ja_s      = {1'b0, step_r[1:0]} + 3'd1;
    assign jb_s      = ja_s + 3'd1;
    assign emit_nx_s = step_r[2:0] + 3'd1;

    assign ax_s = $signed({1'b0, slot_r[ja_s][30:21]}) - $signed({1'b0, slot_r[3'd0][30:21]});
    assign ay_s = $signed({1'b0, slot_r[ja_s][20:11]}) - $signed({1'b0, slot_r[3'd0][20:11]});
    assign bx_s = $signed({1'b0, slot_r[jb_s][30:21]}) - $signed({1'b0, slot_r[3'd0][30:21]});
    assign by_s = $signed({1'b0, slot_r[jb_s][20:11]}) - $signed({1'b0, slot_r[3'd0][20:11]});

    assign prod_ab_s = ax_s * by_s;
    assign prod_ba_s = bx_s * ay_s;
    assign cross_s   = $signed({prod_ab_s[21], prod_ab_s}) - $signed({prod_ba_s[21], prod_ba_s});
    // Only a strictly clockwise pair swaps, so collinear samples keep capture order.
    assign swap_s    = (state_r == SORT) && cross_s[22];

    // Next-state decode for the LOAD/SORT/EMIT sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOAD: begin
                if (bus.in_valid && (cnt_r == 3'd5)) state_nx_s = SORT;
                else                                 state_nx_s = LOAD;
            end
            SORT: begin
                if (step_r == 4'd15) state_nx_s = EMIT;
                else                 state_nx_s = SORT;
            end
            EMIT: begin
                if (step_r == 4'd5) state_nx_s = LOAD;
                else                state_nx_s = EMIT;
            end
            default: state_nx_s = LOAD;
        endcase
    end

    // State register; busy follows the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LOAD;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != LOAD);
        end
    end

    // Capture counter, schedule step counter and slot storage with in-place swaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= 3'd0;
            step_r <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                slot_r[i] <= 34'd0;
            end
        end else begin
            case (state_r)
                LOAD: begin
                    step_r <= 4'd0;
                    if (bus.in_valid) begin
                        slot_r[cnt_r] <= {cnt_r, bus.X, bus.Y, bus.R};
                        cnt_r         <= (cnt_r == 3'd5) ? 3'd0 : cnt_r + 3'd1;
                    end
                end
                SORT: begin
                    step_r <= step_r + 4'd1;
                    if (swap_s) begin
                        slot_r[ja_s] <= slot_r[jb_s];
                        slot_r[jb_s] <= slot_r[ja_s];
                    end
                end
                EMIT: begin
                    step_r <= (step_r == 4'd5) ? 4'd0 : step_r + 4'd1;
                end
                default: begin
                    step_r <= 4'd0;
                    cnt_r  <= 3'd0;
                end
            endcase
        end
    end

    // Output registers: slot 0 is preloaded on the last compare so EMIT starts without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_idx_r   <= 3'd0;
            out_x_r     <= 10'd0;
            out_y_r     <= 10'd0;
            out_r_r     <= 11'd0;
        end else if ((state_r == SORT) && (step_r == 4'd15)) begin
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            {out_idx_r, out_x_r, out_y_r, out_r_r} <= slot_r[3'd0];
        end else if ((state_r == EMIT) && (step_r != 4'd5)) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (step_r == 4'd4);
            {out_idx_r, out_x_r, out_y_r, out_r_r} <= slot_r[emit_nx_s];
        end else begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_X     = out_x_r;
    assign bus.out_Y     = out_y_r;
    assign bus.out_R     = out_r_r;
endmodule

// File: tb/tb_geofence_sort_ctrl.sv
// Scoreboard bench for geofence_sort_ctrl: a reference stable insertion sort predicts each burst.
module tb_geofence_sort_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    geofence_sort_ctrl_if gif();

    geofence_sort_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [10:0] r;
        logic        last;
        int          t_first;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   busy_from  = 0;
    int   busy_until = -1;
    int   m_cnt = 0;
    int   m_x[6];
    int   m_y[6];
    int   m_r[6];
    int   ox[6][6];
    int   oy[6][6];
    int   orr[6][6];
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d required %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit mbusy(input int t);
        return (t >= busy_from) && (t <= busy_until);
    endfunction

    function automatic int mcross(input int a, input int b);
        int ax, ay, bx, by;
        ax = m_x[a] - m_x[0];
        ay = m_y[a] - m_y[0];
        bx = m_x[b] - m_x[0];
        by = m_y[b] - m_y[0];
        return ax * by - bx * ay;
    endfunction

    // Reference: stable insertion sort by cross product, results queued with timing.
    task automatic model_finish(input int c);
        int ord[6];
        exp_t e;
        ord[0] = 0;
        for (int i = 1; i < 6; i++) begin
            int p = i;
            while (p > 1 && mcross(ord[p-1], i) < 0) begin
                ord[p] = ord[p-1];
                p--;
            end
            ord[p] = i;
        end
        for (int k = 0; k < 6; k++) begin
            e.idx     = 3'(ord[k]);
            e.x       = 10'(m_x[ord[k]]);
            e.y       = 10'(m_y[ord[k]]);
            e.r       = 11'(m_r[ord[k]]);
            e.last    = (k == 5);
            e.t_first = (k == 0) ? c + 17 : -1;
            q.push_back(e);
        end
        busy_from  = c + 1;
        busy_until = c + 22;
    endtask

    task automatic drive(input bit v, input int x, input int y, input int r);
        gif.in_valid = v;
        gif.X = 10'(x);
        gif.Y = 10'(y);
        gif.R = 11'(r);
        if (v && !mbusy(cyc)) begin
            m_x[m_cnt] = x;
            m_y[m_cnt] = y;
            m_r[m_cnt] = r;
            m_cnt++;
            if (m_cnt == 6) begin
                model_finish(cyc);
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: idle while busy; 1: load gaps and random junk pulses while busy; 2: in_valid held high
    task automatic send_object(input int o, input int mode);
        int k = 0;
        int guard = 0;
        while (k < 6 && guard < 200) begin
            guard++;
            if (!mbusy(cyc) && !(mode == 1 && $urandom_range(0, 2) == 0)) begin
                drive(1'b1, ox[o][k], oy[o][k], orr[o][k]);
                k++;
            end else begin
                drive(mbusy(cyc) && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 2047)));
            end
        end
        check("send_guard", 32'(k), 32'd6);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gif.in_valid = 1'b0;
        busy_until = cyc;
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(gif.busy), 32'd0);
        check("rst_valid", 32'(gif.out_valid), 32'd0);
    endtask

    // Per-cycle busy window check and scoreboard pop on every emitted sample.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(gif.busy), 32'(mbusy(cyc)));
            if (gif.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 32'(gif.out_valid), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("out_idx", 32'(gif.out_idx), 32'(mon_e.idx));
                    check("out_X", 32'(gif.out_X), 32'(mon_e.x));
                    check("out_Y", 32'(gif.out_Y), 32'(mon_e.y));
                    check("out_R", 32'(gif.out_R), 32'(mon_e.r));
                    check("out_last", 32'(gif.out_last), 32'(mon_e.last));
                    if (mon_e.t_first >= 0) check("latency", 32'(cyc), 32'(mon_e.t_first));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    initial begin
        ox[0] = '{100, 100, 450, 400, 300, 50};   oy[0] = '{100, 350, 300, 100, 400, 300};
        ox[1] = '{100, 400, 450, 300, 100, 50};   oy[1] = '{100, 100, 300, 400, 350, 300};
        ox[2] = '{100, 200, 300, 300, 100, 50};   oy[2] = '{100, 200, 300, 400, 350, 300};
        ox[3] = '{1023, 0, 0, 1023, 512, 0};      oy[3] = '{0, 0, 1023, 1023, 1023, 1};
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 6; k++) orr[o][k] = 10 * k;
        end
        for (int o = 4; o < 6; o++) begin
            ox[o][0]  = int'($urandom_range(0, 1023));
            oy[o][0]  = int'($urandom_range(0, 300));
            orr[o][0] = int'($urandom_range(0, 2047));
            for (int k = 1; k < 6; k++) begin
                ox[o][k]  = int'($urandom_range(0, 1023));
                oy[o][k]  = int'($urandom_range(oy[o][0] + 1, 1023));
                orr[o][k] = int'($urandom_range(0, 2047));
            end
        end

        gif.in_valid = 1'b0;
        gif.X = 10'd0;
        gif.Y = 10'd0;
        gif.R = 11'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(gif.busy), 32'd0);
        check("reset_valid", 32'(gif.out_valid), 32'd0);
        check("reset_last", 32'(gif.out_last), 32'd0);
        check("reset_idx", 32'(gif.out_idx), 32'd0);
        check("reset_X", 32'(gif.out_X), 32'd0);
        check("reset_Y", 32'(gif.out_Y), 32'd0);
        check("reset_R", 32'(gif.out_R), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        send_object(0, 0);
        send_object(1, 1);
        send_object(2, 1);
        send_object(3, 1);
        send_object(4, 0);

        // abort mid-SORT: 6th sample was in cycle c, now in c+1, reset lands in SORT cycle 8
        send_object(0, 0);
        repeat (7) drive(1'b0, 0, 0, 0);
        do_reset();
        send_object(1, 0);

        send_object(5, 2);
        send_object(0, 2);

        begin
            int b = 0;
            while ((q.size() != 0 || mbusy(cyc)) && b < 100) begin
                drive(1'b0, 0, 0, 0);
                b++;
            end
            check("drain", 32'(q.size()), 32'd0);
        end
        drive(1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
